thrsh_ttl_pulse_gen: RTL and testbench
======================================

THRSH_TTL_PULSE_GEN -- requirements
Module: thrsh_ttl_pulse_gen

Interface
REQ-001 The block SHALL have parameter SAMPLE_STATE, default 32'd99, the main_state value that marks the per-channel sample point.
REQ-002 The block SHALL have parameter SAMPLE_CHANNEL, default 6'd0, the channel value that marks the per-frame sample point.
REQ-003 The block SHALL have port dataclk, input, 1, the single system clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, the asynchronous active-low reset (0 = reset asserted).
REQ-005 The block SHALL have port main_state, input, 32, the sequencer state count shared with the DAC output stage.
REQ-006 The block SHALL have port channel, input, 6, the current amplifier channel slot.
REQ-007 The block SHALL have port thrsh_in, input, 1, the threshold comparator output of the DAC output stage, already polarity-corrected.
REQ-008 The block SHALL have port enable, input, 1, which permits pulse generation when high.
REQ-009 The block SHALL have port pulse_len, input, 16, the TTL high time in sample strobes.
REQ-010 The block SHALL have port refractory_len, input, 16, the dead time after a pulse in sample strobes.
REQ-011 The block SHALL have port clear_count, input, 1, a synchronous clear of event_count.
REQ-012 The block SHALL have port ttl_out, output, 1, the registered TTL pulse.
REQ-013 The block SHALL have port state, output, 2, the FSM state: 0 IDLE, 1 PULSE, 2 REFRACT.
REQ-014 The block SHALL have port event_count, output, 16, the number of accepted events, saturating.

Function
REQ-015 strobe SHALL be the combinational term (main_state == SAMPLE_STATE) && (channel == SAMPLE_CHANNEL); all timing SHALL be counted in strobes, not clocks.
REQ-016 thrsh_prev SHALL load thrsh_in only on strobe cycles; edge = strobe && thrsh_in && !thrsh_prev.
REQ-017 IDLE -> PULSE SHALL occur when edge && enable && pulse_len != 0; on that edge ttl_out goes 1, pulse_len and refractory_len are latched, the down-counter loads the latched pulse_len, and event_count increments.
REQ-018 An edge with pulse_len == 0 SHALL keep the FSM in IDLE and leave event_count unchanged.
REQ-019 In PULSE the counter SHALL decrement once per strobe, and ttl_out SHALL stay high for exactly the latched pulse_len strobes, falling on the clock edge that samples the pulse_len-th strobe after entry.
REQ-020 At PULSE end the FSM SHALL go to REFRACT with the counter loaded from the latched refractory_len if that value is nonzero, and to IDLE otherwise, with ttl_out 0 from that edge in both cases.
REQ-021 REFRACT SHALL count the latched refractory_len strobes, then go to IDLE.
REQ-022 Edges arriving in PULSE or REFRACT SHALL be ignored: no retrigger, no count.
REQ-023 An edge that coincides with the strobe on which REFRACT ends SHALL be ignored, and a new pulse SHALL need an edge on a later strobe.
REQ-024 Changes to pulse_len or refractory_len during PULSE or REFRACT SHALL NOT affect the interval in progress.
REQ-025 enable low in any state SHALL force IDLE, ttl_out 0 and counter 0 on the next clock edge; thrsh_prev keeps tracking.
REQ-026 event_count SHALL saturate at 16'hFFFF.
REQ-027 clear_count SHALL set event_count to 0, and clear_count coincident with an accepted event SHALL yield 1.
REQ-028 ttl_out, state and event_count SHALL all be registered, with no combinational path from any input.

Reset
REQ-029 While reset is 0 the block SHALL hold state = IDLE, ttl_out = 0, counter = 0, event_count = 0, thrsh_prev = 1 and latched lengths = 0.
REQ-030 Reset assertion mid-PULSE or mid-REFRACT SHALL clear ttl_out immediately (asynchronously).
REQ-031 Because thrsh_prev resets to 1, an input already high at reset release SHALL NOT fire until it has been low on at least one strobe.

Verification
REQ-032 Basic pulse: pulse_len=3, refractory_len=2, thrsh_in 0->1 before strobe k -> ttl_out high from strobe k through strobe k+3 edge (3 strobes), REFRACT 2 strobes, event_count=1.
REQ-033 Dead time: thrsh_in toggles 0/1 on every strobe, pulse_len=2, refractory_len=4 -> a pulse starts only every 6+ strobes and event_count equals the number of pulses.
REQ-034 Zero lengths: pulse_len=0 with an edge -> ttl_out stays 0 and count 0; pulse_len=1, refractory_len=0 -> a 1-strobe pulse then direct IDLE.
REQ-035 Abort: enable dropped at the 2nd strobe of a pulse_len=10 pulse -> ttl_out 0 one clock later and state=0; reset pulsed low mid-REFRACT -> all outputs 0 asynchronously.
REQ-036 Counter limits: preload activity to 16'hFFFF with more edges -> count holds at FFFF; clear_count coincident with an edge -> count=1.
REQ-037 Strobe gating: edges on non-strobe cycles (main_state != 99 or channel != 0) that return low before the next strobe -> no pulse.

Source files
------------

// File: rtl/thrsh_ttl_pulse_gen.sv
// Threshold-triggered TTL pulse generator: one pulse per accepted rising edge of thrsh_in,
// with pulse width and refractory dead time counted in sequencer sample strobes.
module thrsh_ttl_pulse_gen #(
    parameter logic [31:0] SAMPLE_STATE   = 32'd99,
    parameter logic [5:0]  SAMPLE_CHANNEL = 6'd0
) (
    input  logic        dataclk,
    input  logic        reset,
    input  logic [31:0] main_state,
    input  logic [5:0]  channel,
    input  logic        thrsh_in,
    input  logic        enable,
    input  logic [15:0] pulse_len,
    input  logic [15:0] refractory_len,
    input  logic        clear_count,
    output logic        ttl_out,
    output logic [1:0]  state,
    output logic [15:0] event_count
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StPulse   = 2'd1,
        StRefract = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        ttl_q, ttl_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] plen_q, plen_d;
    logic [15:0] rlen_q, rlen_d;
    logic [15:0] event_count_q, event_count_d;
    logic        thrsh_prev_q, thrsh_prev_d;

    logic strobe;
    logic edge_det;
    logic accept;

    assign strobe   = (main_state == SAMPLE_STATE) && (channel == SAMPLE_CHANNEL);
    assign edge_det = strobe && thrsh_in && !thrsh_prev_q;

    // The comparator history only advances on strobes so edges are seen per sample.
    assign thrsh_prev_d = strobe ? thrsh_in : thrsh_prev_q;

    always_comb begin
        state_d = state_q;
        ttl_d   = ttl_q;
        cnt_d   = cnt_q;
        plen_d  = plen_q;
        rlen_d  = rlen_q;
        accept  = 1'b0;

        if (!enable) begin
            state_d = StIdle;
            ttl_d   = 1'b0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (edge_det && (pulse_len != 16'd0)) begin
                        accept  = 1'b1;
                        state_d = StPulse;
                        ttl_d   = 1'b1;
                        plen_d  = pulse_len;
                        rlen_d  = refractory_len;
                        cnt_d   = pulse_len;
                    end
                end
                StPulse: begin
                    if (strobe) begin
                        if (cnt_q == 16'd1) begin
                            ttl_d = 1'b0;
                            if (rlen_q != 16'd0) begin
                                state_d = StRefract;
                                cnt_d   = rlen_q;
                            end else begin
                                state_d = StIdle;
                                cnt_d   = '0;
                            end
                        end else begin
                            cnt_d = cnt_q - 16'd1;
                        end
                    end
                end
                StRefract: begin
                    // Edges on the final refractory strobe fall here and are dropped.
                    if (strobe) begin
                        if (cnt_q == 16'd1) begin
                            state_d = StIdle;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q - 16'd1;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                    ttl_d   = 1'b0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        event_count_d = event_count_q;
        if (clear_count) begin
            event_count_d = {15'd0, accept};
        end else if (accept && (event_count_q != 16'hFFFF)) begin
            event_count_d = event_count_q + 16'd1;
        end
    end

    always_ff @(posedge dataclk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            ttl_q         <= 1'b0;
            cnt_q         <= '0;
            plen_q        <= '0;
            rlen_q        <= '0;
            event_count_q <= '0;
            thrsh_prev_q  <= 1'b1;
        end else begin
            state_q       <= state_d;
            ttl_q         <= ttl_d;
            cnt_q         <= cnt_d;
            plen_q        <= plen_d;
            rlen_q        <= rlen_d;
            event_count_q <= event_count_d;
            thrsh_prev_q  <= thrsh_prev_d;
        end
    end

    assign ttl_out     = ttl_q;
    assign state       = state_q;
    assign event_count = event_count_q;

    // An active interval never holds more strobes than the length latched at its start.
    a_pulse_bound: assert property (@(posedge dataclk) disable iff (!reset)
        (state_q == StPulse) |-> ((cnt_q != 16'd0) && (cnt_q <= plen_q)));
    a_refract_bound: assert property (@(posedge dataclk) disable iff (!reset)
        (state_q == StRefract) |-> ((cnt_q != 16'd0) && (cnt_q <= rlen_q)));

endmodule

// File: tb/tb_thrsh_ttl_pulse_gen.sv
// Scoreboard bench for thrsh_ttl_pulse_gen: a strobe-level reference model predicts the
// registered outputs for every driven cycle, and the queue is drained after each clock edge.
module tb_thrsh_ttl_pulse_gen;

    logic        dataclk;
    logic        reset;
    logic [31:0] main_state;
    logic [5:0]  channel;
    logic        thrsh_in;
    logic        enable;
    logic [15:0] pulse_len;
    logic [15:0] refractory_len;
    logic        clear_count;
    logic        ttl_out;
    logic [1:0]  state;
    logic [15:0] event_count;

    thrsh_ttl_pulse_gen dut (
        .dataclk        (dataclk),
        .reset          (reset),
        .main_state     (main_state),
        .channel        (channel),
        .thrsh_in       (thrsh_in),
        .enable         (enable),
        .pulse_len      (pulse_len),
        .refractory_len (refractory_len),
        .clear_count    (clear_count),
        .ttl_out        (ttl_out),
        .state          (state),
        .event_count    (event_count)
    );

    initial dataclk = 1'b0;
    always #5 dataclk = ~dataclk;

    typedef struct packed {
        logic        ttl;
        logic [1:0]  st;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb_q[$];

    int n_vec  = 0;
    int n_miss = 0;
    int hi_strobes = 0;

    // Reference model state
    logic [1:0]  m_state;
    logic        m_ttl;
    logic [15:0] m_cnt;
    logic [15:0] m_left;
    logic [15:0] m_rlen;
    logic        m_prev;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 2'd0;
        m_ttl   = 1'b0;
        m_cnt   = 16'd0;
        m_left  = 16'd0;
        m_rlen  = 16'd0;
        m_prev  = 1'b1;
    endtask

    task automatic model_step(input logic strb, input logic th);
        logic rise;
        logic take;
        rise = strb && th && !m_prev;
        take = 1'b0;
        if (!enable) begin
            m_state = 2'd0;
            m_ttl   = 1'b0;
            m_left  = 16'd0;
        end else if (m_state == 2'd0) begin
            if (rise && (pulse_len != 16'd0)) begin
                take    = 1'b1;
                m_state = 2'd1;
                m_ttl   = 1'b1;
                m_left  = pulse_len;
                m_rlen  = refractory_len;
            end
        end else if (strb) begin
            m_left = m_left - 16'd1;
            if (m_left == 16'd0) begin
                m_ttl = 1'b0;
                if ((m_state == 2'd1) && (m_rlen != 16'd0)) begin
                    m_state = 2'd2;
                    m_left  = m_rlen;
                end else begin
                    m_state = 2'd0;
                end
            end
        end
        if (clear_count) m_cnt = take ? 16'd1 : 16'd0;
        else if (take && (m_cnt != 16'hFFFF)) m_cnt = m_cnt + 16'd1;
        if (strb) m_prev = th;
    endtask

    // Inputs that leave no trace: no strobe, no clear.
    task automatic park();
        main_state  = 32'd0;
        channel     = 6'd0;
        clear_count = 1'b0;
    endtask

    // kind 0: sample strobe, 1: wrong main_state, 2: wrong channel
    task automatic cycle(input int kind, input logic th);
        exp_t e;
        @(negedge dataclk);
        if ((kind == 0) && ttl_out) hi_strobes++;
        main_state = (kind == 1) ? 32'd98 : 32'd99;
        channel    = (kind == 2) ? 6'd1 : 6'd0;
        thrsh_in   = th;
        model_step(kind == 0, th);
        sb_q.push_back('{ttl: m_ttl, st: m_state, cnt: m_cnt});
        @(posedge dataclk);
        #1;
        e = sb_q.pop_front();
        check("ttl_out", {31'd0, ttl_out}, {31'd0, e.ttl});
        check("state", {30'd0, state}, {30'd0, e.st});
        check("event_count", {16'd0, event_count}, {16'd0, e.cnt});
        park();
    endtask

    task automatic async_reset(input string tag);
        @(negedge dataclk);
        #2;
        reset = 1'b0;
        #1;
        check({tag, "_ttl"}, {31'd0, ttl_out}, 32'd0);
        check({tag, "_state"}, {30'd0, state}, 32'd0);
        check({tag, "_count"}, {16'd0, event_count}, 32'd0);
        model_reset();
        @(negedge dataclk);
        reset = 1'b1;
    endtask

    initial begin
        int rises;
        logic last_ttl;

        reset          = 1'b0;
        enable         = 1'b0;
        thrsh_in       = 1'b0;
        pulse_len      = 16'd0;
        refractory_len = 16'd0;
        park();
        model_reset();
        repeat (3) @(posedge dataclk);
        #1;
        check("rst_ttl", {31'd0, ttl_out}, 32'd0);
        check("rst_state", {30'd0, state}, 32'd0);
        check("rst_count", {16'd0, event_count}, 32'd0);
        @(negedge dataclk);
        reset = 1'b1;

        // Basic pulse with a mid-pulse length change that must not take effect
        enable         = 1'b1;
        pulse_len      = 16'd3;
        refractory_len = 16'd2;
        cycle(0, 1'b0);
        cycle(1, 1'b0);
        cycle(0, 1'b1);
        check("basic_start", {31'd0, ttl_out}, 32'd1);
        hi_strobes = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 1) pulse_len = 16'd7;
            cycle(1, 1'b1);
            cycle(0, 1'b1);
        end
        check("basic_width", hi_strobes, 32'd3);
        check("basic_count", {16'd0, event_count}, 32'd1);

        // Dead time: toggling input on every strobe
        pulse_len      = 16'd2;
        refractory_len = 16'd4;
        clear_count    = 1'b1;
        cycle(0, 1'b0);
        rises    = 0;
        last_ttl = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cycle(0, (i % 2) == 0);
            if (ttl_out && !last_ttl) rises++;
            last_ttl = ttl_out;
        end
        check("dead_count", {16'd0, event_count}, rises);
        check("dead_rate", (rises >= 5 && rises <= 7) ? 32'd1 : 32'd0, 32'd1);

        // Zero pulse length, then a one-strobe pulse with no refractory
        repeat (8) cycle(0, 1'b0);
        clear_count = 1'b1;
        cycle(0, 1'b0);
        pulse_len = 16'd0;
        cycle(0, 1'b1);
        cycle(0, 1'b0);
        check("zero_count", {16'd0, event_count}, 32'd0);
        pulse_len      = 16'd1;
        refractory_len = 16'd0;
        cycle(0, 1'b1);
        cycle(0, 1'b0);
        check("one_idle", {30'd0, state}, 32'd0);

        // Strobe gating: excursions between strobes are invisible
        cycle(1, 1'b1);
        cycle(1, 1'b0);
        cycle(2, 1'b1);
        cycle(2, 1'b0);
        cycle(0, 1'b0);
        check("gate_ttl", {31'd0, ttl_out}, 32'd0);

        // Abort by enable at the second strobe of a long pulse
        pulse_len      = 16'd10;
        refractory_len = 16'd3;
        cycle(0, 1'b1);
        cycle(0, 1'b0);
        enable = 1'b0;
        cycle(0, 1'b0);
        check("abort_ttl", {31'd0, ttl_out}, 32'd0);
        check("abort_state", {30'd0, state}, 32'd0);
        enable = 1'b1;
        cycle(0, 1'b0);

        // Asynchronous reset mid-REFRACT and mid-PULSE
        pulse_len      = 16'd1;
        refractory_len = 16'd5;
        cycle(0, 1'b1);
        cycle(0, 1'b0);
        check("pre_rst_state", {30'd0, state}, 32'd2);
        async_reset("arst_refr");
        pulse_len = 16'd10;
        cycle(0, 1'b0);
        cycle(0, 1'b1);
        async_reset("arst_pulse");

        // Input high across reset release must go low before it can fire
        cycle(0, 1'b1);
        cycle(0, 1'b1);
        check("held_high", {31'd0, ttl_out}, 32'd0);
        cycle(0, 1'b0);
        cycle(0, 1'b1);
        check("relow_fire", {31'd0, ttl_out}, 32'd1);
        enable = 1'b0;
        cycle(0, 1'b0);
        enable = 1'b1;

        // Saturation, then clear coincident with an accepted event
        @(negedge dataclk);
        force dut.event_count_q = 16'hFFFD;
        #1;
        release dut.event_count_q;
        m_cnt          = 16'hFFFD;
        pulse_len      = 16'd1;
        refractory_len = 16'd0;
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1'b0);
            cycle(0, 1'b1);
        end
        check("sat_count", {16'd0, event_count}, 32'hFFFF);
        cycle(0, 1'b0);
        clear_count = 1'b1;
        cycle(0, 1'b1);
        check("clr_edge_count", {16'd0, event_count}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
